ebus_diag_arb: RTL

Arbiter and sequencer for EBUS diagnostic-function cycles. Shares the single EBUS diagnostic port (`ds`, `diagStrobe`, DTE data driver) between up to `NREQ` requesters, for example the front-end DTE path and a console/diagnostic scheduler. It grants requesters round-robin and runs each granted request as one fixed-length strobe/recovery cycle. It captures read data, then returns a one-clock acknowledge to the winning requester.

---
 rtl/ebus_diag_arb.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ebus_diag_arb.sv
// ebus_diag_arb: round-robin arbiter and sequencer for EBUS diagnostic cycles.
// Each granted request runs one strobe/recovery cycle on the shared diagnostic
// port, captures read data, then pulses a one-clock ack to the winner.
// Optional feature macro: EBUS_DIAG_LOCK_EN (lets a winner keep the bus while
// it holds reqLock).
module ebus_diag_arb #(
  parameter int                 NREQ          = 2,
  parameter int                 FUNC_W        = 7,
  parameter logic [FUNC_W-1:0]  DS_IDLE       = 7'o0,
  parameter int                 STROBE_CYCLES = 8,
  parameter int                 GAP_CYCLES    = 7
) (
  input  logic                 clk,
  input  logic                 CROBAR,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      reqWrite,
  input  logic [NREQ*FUNC_W-1:0] reqFunc,
  input  logic [NREQ*36-1:0]   reqData,
  input  logic [NREQ-1:0]      reqLock,
  output logic [NREQ-1:0]      ack,
  output logic [35:0]          rdData,
  output logic [FUNC_W-1:0]    ebusDs,
  output logic                 ebusDiagStrobe,
  output logic                 ebusDriving,
  output logic [35:0]          ebusDriveData,
  input  logic [35:0]          ebusData,
  output logic                 busy
);

  localparam int MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   last;
  logic            write_q;
  logic            lock_hold;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   cand;
  logic            found;

  // reqLock only matters when the lock feature is compiled in
  logic unused_lock;
  assign unused_lock = ^reqLock;

  // Pick the next winner: search from last+1 with wrap, or re-grant a locked winner
  always_comb begin
    grant_idx = last;
    cand      = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (lock_hold && req[last]) begin
      found     = 1'b1;
      grant_idx = last;
    end
  end

  // Cycle sequencer; every output is a register updated here
  always_ff @(posedge clk) begin
    if (CROBAR) begin
      state          <= IDLE;
      cnt            <= '0;
      last           <= PW'(NREQ - 1);
      write_q        <= 1'b0;
      lock_hold      <= 1'b0;
      ack            <= '0;
      rdData         <= '0;
      ebusDs         <= DS_IDLE;
      ebusDiagStrobe <= 1'b0;
      ebusDriving    <= 1'b0;
      ebusDriveData  <= '0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack       <= '0;
          lock_hold <= 1'b0;
          if (found) begin
            last           <= grant_idx;
            write_q        <= reqWrite[grant_idx];
            ebusDs         <= reqFunc[int'(grant_idx)*FUNC_W +: FUNC_W];
            ebusDiagStrobe <= 1'b1;
            ebusDriving    <= reqWrite[grant_idx];
            ebusDriveData  <= reqWrite[grant_idx] ? reqData[int'(grant_idx)*36 +: 36] : 36'd0;
            busy           <= 1'b1;
            cnt            <= CW'(STROBE_CYCLES - 1);
            state          <= STROBE;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            ebusDs         <= DS_IDLE;
            ebusDiagStrobe <= 1'b0;
            ebusDriving    <= 1'b0;
            ebusDriveData  <= '0;
            if (!write_q) begin
              rdData <= ebusData;
            end
            cnt            <= CW'(GAP_CYCLES - 1);
            state          <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            ack   <= NREQ'(1) << last;
            cnt   <= '0;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
`ifdef EBUS_DIAG_LOCK_EN
          lock_hold <= reqLock[last] & req[last];
`else
          lock_hold <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
